// File: rtl/mux_arb_pkg.sv
// Shared definitions for the 4-way round-robin mux select arbiter.
package mux_arb_pkg;
   localparam int NUM_REQ = 4;
   localparam int IDX_W   = 2;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_OWN  = 1'b1
   } arb_state_e;

   function automatic logic [NUM_REQ-1:0] idx2oh(input logic [IDX_W-1:0] idx);
      return NUM_REQ'(1) << idx;
   endfunction
endpackage

// File: rtl/rr_pick4.sv
// Combinational round-robin pick: first set request at or after i_ptr, modulo 4.
module rr_pick4
   import mux_arb_pkg::*;
(
   input  logic [NUM_REQ-1:0] i_req,
   input  logic [IDX_W-1:0]   i_ptr,
   output logic               o_vld,
   output logic [IDX_W-1:0]   o_idx
);
   logic [2*NUM_REQ-1:0] w_dbl;
   logic [NUM_REQ-1:0]   w_rot;
   logic [IDX_W-1:0]     w_off;

   // Rotate so that bit 0 of w_rot is the requester sitting at the pointer.
   assign w_dbl = {i_req, i_req};
   assign w_rot = w_dbl[i_ptr +: NUM_REQ];

   always_comb begin
      w_off = '0;
      for (int j = NUM_REQ-1; j >= 0; j--) begin
         if (w_rot[j]) w_off = IDX_W'(j);
      end
   end

   assign o_vld = |i_req;
   assign o_idx = i_ptr + w_off;
endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin owner arbiter driving the select lines of an external mux4to1.
// Optional hold-time limit enabled by defining MUX4_ARB_TIMEOUT_EN.
module mux4_rr_arbiter
   import mux_arb_pkg::*;
#(
   parameter int HOLD_MAX = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NUM_REQ-1:0] req,
   input  logic               done,
   output logic [NUM_REQ-1:0] grant,
   output logic               s0,
   output logic               s1,
   output logic               busy,
   output logic               timeout
);
   if (HOLD_MAX < 2 || HOLD_MAX > 255) begin : g_bad_hold
      $error("HOLD_MAX must be in 2..255");
   end

   arb_state_e         r_state;
   logic [IDX_W-1:0]   r_ptr;
   logic [IDX_W-1:0]   r_owner;
   logic [NUM_REQ-1:0] r_grant;
   logic               r_busy;

   logic               w_forced;
   logic               w_release;
   logic [NUM_REQ-1:0] w_pick_req;
   logic [IDX_W-1:0]   w_pick_ptr;
   logic               w_pick_vld;
   logic [IDX_W-1:0]   w_pick_idx;

`ifdef MUX4_ARB_TIMEOUT_EN
   logic [7:0] r_hold;
   logic       r_timeout;

   assign w_forced = (r_hold == 8'(HOLD_MAX));
   assign timeout  = r_timeout;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_hold    <= '0;
         r_timeout <= 1'b0;
      end else begin
         r_timeout <= 1'b0;
         if (r_state == ST_IDLE) begin
            if (w_pick_vld) r_hold <= 8'd1;
         end else if (w_release) begin
            r_hold    <= w_pick_vld ? 8'd1 : 8'd0;
            // Flag only releases that the owner did not ask for itself.
            r_timeout <= w_forced && !done && req[r_owner];
         end else begin
            r_hold <= r_hold + 8'd1;
         end
      end
   end
`else
   assign w_forced = 1'b0;
   assign timeout  = 1'b0;
`endif

   // Dropping req counts as an implicit done.
   assign w_release = (r_state == ST_OWN) && (done || !req[r_owner] || w_forced);

   // On handover the releasing owner is masked so it cannot win its own edge.
   assign w_pick_req = (r_state == ST_OWN) ? (req & ~r_grant) : req;
   assign w_pick_ptr = (r_state == ST_OWN) ? (r_owner + 2'd1) : r_ptr;

   rr_pick4 u_pick (
      .i_req (w_pick_req),
      .i_ptr (w_pick_ptr),
      .o_vld (w_pick_vld),
      .o_idx (w_pick_idx)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_ptr   <= '0;
         r_owner <= '0;
         r_grant <= '0;
         r_busy  <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_pick_vld) begin
                  r_state <= ST_OWN;
                  r_owner <= w_pick_idx;
                  r_grant <= idx2oh(w_pick_idx);
                  r_busy  <= 1'b1;
               end
            end
            ST_OWN: begin
               if (w_release) begin
                  r_ptr <= r_owner + 2'd1;
                  if (w_pick_vld) begin
                     r_owner <= w_pick_idx;
                     r_grant <= idx2oh(w_pick_idx);
                  end else begin
                     r_state <= ST_IDLE;
                     r_owner <= '0;
                     r_grant <= '0;
                     r_busy  <= 1'b0;
                  end
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign grant = r_grant;
   assign s0    = r_owner[0];
   assign s1    = r_owner[1];
   assign busy  = r_busy;
endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Self-checking bench for mux4_rr_arbiter; expectations queued per stimulus cycle.
module tb_mux4_rr_arbiter;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] req = 4'b0000;
   logic       done = 1'b0;
   logic [3:0] grant;
   logic       s0, s1, busy, timeout;

   int n_chk  = 0;
   int n_pass = 0;
   logic [7:0] exp_q [$];

   always #5 clk = ~clk;

   mux4_rr_arbiter #(.HOLD_MAX(4)) dut (
      .clk     (clk),
      .rst     (rst),
      .req     (req),
      .done    (done),
      .grant   (grant),
      .s0      (s0),
      .s1      (s1),
      .busy    (busy),
      .timeout (timeout)
   );

   // Expected {timeout, busy, s1, s0, grant} for a given one-hot grant.
   function automatic logic [7:0] exp_of(input logic [3:0] g, input logic to);
      logic [1:0] ix;
      ix = 2'b00;
      for (int k = 0; k < 4; k++) if (g[k]) ix = k[1:0];
      return {to, |g, ix, g};
   endfunction

   // Stimulus entries are {rst, done, req}; expectations are {timeout, grant}.
   task automatic test_reset();
      logic [5:0] st [3];
      logic [4:0] eg [3];
      logic [7:0] e, obs;
      st = '{6'b100000, 6'b111111, 6'b100000};
      eg = '{5'b00000, 5'b00000, 5'b00000};
      for (int i = 0; i < 3; i++) begin
         {rst, done, req} = st[i];
         exp_q.push_back(exp_of(eg[i][3:0], eg[i][4]));
         @(posedge clk); #1;
         e = exp_q.pop_front();
         obs = {timeout, busy, s1, s0, grant};
         n_chk++;
         if (obs !== e) $display("FAIL reset[%0d]: got %b want %b", i, obs, e);
         else n_pass++;
      end
   endtask

   task automatic test_single();
      logic [5:0] st [3];
      logic [4:0] eg [3];
      logic [7:0] e, obs;
      st = '{6'b100000, 6'b000100, 6'b000000};
      eg = '{5'b00000, 5'b00100, 5'b00000};
      for (int i = 0; i < 3; i++) begin
         {rst, done, req} = st[i];
         exp_q.push_back(exp_of(eg[i][3:0], eg[i][4]));
         @(posedge clk); #1;
         e = exp_q.pop_front();
         obs = {timeout, busy, s1, s0, grant};
         n_chk++;
         if (obs !== e) $display("FAIL single[%0d]: got %b want %b", i, obs, e);
         else n_pass++;
      end
   endtask

   task automatic test_rotate();
      logic [5:0] st [13];
      logic [4:0] eg [13];
      logic [7:0] e, obs;
      st[0] = 6'b100000;
      eg[0] = 5'b00000;
      for (int i = 0; i < 12; i++) st[i+1] = {1'b0, (i % 3 == 2), 4'b1111};
      eg[1]  = 5'b00001; eg[2]  = 5'b00001; eg[3]  = 5'b00010;
      eg[4]  = 5'b00010; eg[5]  = 5'b00010; eg[6]  = 5'b00100;
      eg[7]  = 5'b00100; eg[8]  = 5'b00100; eg[9]  = 5'b01000;
      eg[10] = 5'b01000; eg[11] = 5'b01000; eg[12] = 5'b00001;
      for (int i = 0; i < 13; i++) begin
         {rst, done, req} = st[i];
         exp_q.push_back(exp_of(eg[i][3:0], eg[i][4]));
         @(posedge clk); #1;
         e = exp_q.pop_front();
         obs = {timeout, busy, s1, s0, grant};
         n_chk++;
         if (obs !== e) $display("FAIL rotate[%0d]: got %b want %b", i, obs, e);
         else n_pass++;
      end
   endtask

   task automatic test_done_idle();
      logic [5:0] st [5];
      logic [4:0] eg [5];
      logic [7:0] e, obs;
      st = '{6'b100000, 6'b010000, 6'b000010, 6'b010010, 6'b000010};
      eg = '{5'b00000, 5'b00000, 5'b00010, 5'b00000, 5'b00010};
      for (int i = 0; i < 5; i++) begin
         {rst, done, req} = st[i];
         exp_q.push_back(exp_of(eg[i][3:0], eg[i][4]));
         @(posedge clk); #1;
         e = exp_q.pop_front();
         obs = {timeout, busy, s1, s0, grant};
         n_chk++;
         if (obs !== e) $display("FAIL done_idle[%0d]: got %b want %b", i, obs, e);
         else n_pass++;
      end
   endtask

   task automatic test_implicit_release();
      logic [5:0] st [5];
      logic [4:0] eg [5];
      logic [7:0] e, obs;
      st = '{6'b100000, 6'b000100, 6'b001001, 6'b001001, 6'b011001};
      eg = '{5'b00000, 5'b00100, 5'b01000, 5'b01000, 5'b00001};
      for (int i = 0; i < 5; i++) begin
         {rst, done, req} = st[i];
         exp_q.push_back(exp_of(eg[i][3:0], eg[i][4]));
         @(posedge clk); #1;
         e = exp_q.pop_front();
         obs = {timeout, busy, s1, s0, grant};
         n_chk++;
         if (obs !== e) $display("FAIL implicit[%0d]: got %b want %b", i, obs, e);
         else n_pass++;
      end
   endtask

   task automatic test_no_preempt();
      logic [5:0] st [6];
      logic [4:0] eg [6];
      logic [7:0] e, obs;
      st = '{6'b100000, 6'b000001, 6'b000011, 6'b000011, 6'b010011, 6'b000001};
      eg = '{5'b00000, 5'b00001, 5'b00001, 5'b00001, 5'b00010, 5'b00001};
      for (int i = 0; i < 6; i++) begin
         {rst, done, req} = st[i];
         exp_q.push_back(exp_of(eg[i][3:0], eg[i][4]));
         @(posedge clk); #1;
         e = exp_q.pop_front();
         obs = {timeout, busy, s1, s0, grant};
         n_chk++;
         if (obs !== e) $display("FAIL no_preempt[%0d]: got %b want %b", i, obs, e);
         else n_pass++;
      end
   endtask

   task automatic test_reset_mid();
      logic [5:0] st [4];
      logic [4:0] eg [4];
      logic [7:0] e, obs;
      st = '{6'b100000, 6'b001000, 6'b101111, 6'b001111};
      eg = '{5'b00000, 5'b01000, 5'b00000, 5'b00001};
      for (int i = 0; i < 4; i++) begin
         {rst, done, req} = st[i];
         exp_q.push_back(exp_of(eg[i][3:0], eg[i][4]));
         @(posedge clk); #1;
         e = exp_q.pop_front();
         obs = {timeout, busy, s1, s0, grant};
         n_chk++;
         if (obs !== e) $display("FAIL reset_mid[%0d]: got %b want %b", i, obs, e);
         else n_pass++;
      end
   endtask

   // With the limit compiled in, owners are cut off after 4 cycles; without it they keep the path.
   task automatic test_timeout();
      logic [5:0] st [10];
      logic [4:0] eg [10];
      logic [7:0] e, obs;
      st[0] = 6'b100000;
      eg[0] = 5'b00000;
      for (int i = 1; i < 10; i++) st[i] = 6'b000011;
`ifdef MUX4_ARB_TIMEOUT_EN
      eg[1] = 5'b00001; eg[2] = 5'b00001; eg[3] = 5'b00001; eg[4] = 5'b00001;
      eg[5] = 5'b10010; eg[6] = 5'b00010; eg[7] = 5'b00010; eg[8] = 5'b00010;
      eg[9] = 5'b10001;
`else
      for (int i = 1; i < 10; i++) eg[i] = 5'b00001;
`endif
      for (int i = 0; i < 10; i++) begin
         {rst, done, req} = st[i];
         exp_q.push_back(exp_of(eg[i][3:0], eg[i][4]));
         @(posedge clk); #1;
         e = exp_q.pop_front();
         obs = {timeout, busy, s1, s0, grant};
         n_chk++;
         if (obs !== e) $display("FAIL timeout[%0d]: got %b want %b", i, obs, e);
         else n_pass++;
      end
   endtask

   initial begin
      #1;
      test_reset();
      test_single();
      test_rotate();
      test_done_idle();
      test_implicit_release();
      test_no_preempt();
      test_reset_mid();
      test_timeout();
      {rst, done, req} = 6'b000000;
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/mux4_rr_arbiter.md
MUX4_RR_ARBITER -- requirements
Module: mux4_rr_arbiter

Interface
REQ-001 SHALL have parameter HOLD_MAX, default 8: maximum cycles one grant may be held when the timeout feature is compiled in (legal range 2..255).
REQ-002 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-004 SHALL have port req, input, 4: req[k] high means requester k wants the shared mux4to1 path.
REQ-005 SHALL have port done, input, 1: current owner releases the path this cycle.
REQ-006 SHALL have port grant, output, 4: one-hot owner indication, all zero when no owner.
REQ-007 SHALL have port s0, output, 1: LSB of owner index, driving mux select s0.
REQ-008 SHALL have port s1, output, 1: MSB of owner index, driving mux select s1.
REQ-009 SHALL have port busy, output, 1: high while any grant is active.
REQ-010 SHALL have port timeout, output, 1: one-cycle pulse on forced release.

Function
REQ-011 SHALL implement two states: IDLE (no owner) and OWN (one owner).
REQ-012 SHALL, in IDLE with any req bit high, enter OWN on the next edge, granting the first requester at or after the priority pointer, searching upward modulo 4.
REQ-013 SHALL keep grant, s0, s1 and busy registered, so they change only on clock edges; request-to-grant latency is 1 cycle.
REQ-014 SHALL drive {s1,s0} equal to the owner index (requester 0 = 00, 1 = 01, 2 = 10, 3 = 11), and 00 in IDLE.
REQ-015 SHALL release the owner on an edge where done is high, or where req[owner] is low (this counts as an implicit done).
REQ-016 SHALL, on release, set the pointer to (owner+1) mod 4.
REQ-017 SHALL, on release with other req bits high, move directly OWN to OWN to the next winner on that same edge, with no idle cycle.
REQ-018 SHALL, on release with no other requests pending, go to IDLE; the releasing requester SHALL NOT be re-granted on that edge even if its req stays high.
REQ-019 SHALL ignore done while in IDLE.
REQ-020 SHALL never assert more than one grant bit; grant SHALL be zero if and only if busy is low.
REQ-021 SHALL treat a req bit rising while another requester owns the path as pending; a non-owner request SHALL NOT preempt the owner.

Reset
REQ-022 SHALL, while rst is high at an edge, force IDLE, pointer=0, grant=0000, s0=s1=0, busy=0, timeout=0, hold counter=0.
REQ-023 SHALL apply reset mid-grant immediately, dropping the owner, with no timeout pulse.
REQ-024 SHALL grant on the first edge after rst deasserts if any req bit is high.

Configuration
REQ-025 SHALL, with macro MUX4_ARB_TIMEOUT_EN defined, count cycles in OWN and force release at the edge ending cycle HOLD_MAX of one grant, pulse timeout for 1 cycle, and advance the pointer as for a normal release.
REQ-026 SHALL, with MUX4_ARB_TIMEOUT_EN undefined, contain no hold counter, tie timeout to 0, and hold ownership indefinitely until release.
REQ-027 SHALL restart the hold counter from 1 on every new grant, including an OWN to OWN handover.

Structure
REQ-028 SHALL place the state encoding (IDLE=0, OWN=1), the requester count (4) and the index width (2) in shared package mux_arb_pkg.
REQ-029 SHALL use one sub-module, rr_pick4: combinational "first set bit at or after pointer, modulo 4", returning a valid flag and a 2-bit index.
REQ-030 SHALL keep the mux4to1 datapath outside this block; s0 and s1 connect to it directly.

Verification
REQ-031 SHALL test: reset, then req=0100 -> next cycle grant=0100, {s1,s0}=10, busy=1.
REQ-032 SHALL test: req=1111 held, done pulsed every 3rd cycle -> grants in order 0001, 0010, 0100, 1000, 0001, with no idle gap.
REQ-033 SHALL test: owner 1, req=0010 only, done=1 -> next cycle IDLE with grant=0000; the cycle after, grant=0010 again.
REQ-034 SHALL test: owner 2, req[2] dropped without done while req=1001 -> next grant=1000 (pointer 3).
REQ-035 SHALL test: rst asserted during owner 3 -> next cycle grant=0000, s0=s1=0; after release of rst with req=1111, grant=0001.
REQ-036 SHALL test: with MUX4_ARB_TIMEOUT_EN and HOLD_MAX=4, req=0011 held, no done -> owner 0 for 4 cycles, timeout pulse, then grant=0010.
